// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion constants: S-box, round constants, FSM states.
// Used by aes_key_schedule_ctrl (optional o_last_key via AES_KEYSCHED_LAST_KEY_EN).
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_RKEYS  = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Row-major S-box; byte 0 sits in bits [0:7].
  localparam logic [0:2047] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// One AES-128 key-expansion word step; purely combinational, shared by all 40 steps.
module aes_key_word_step
  import aes_pkg::*;
(
  input  logic [31:0] prev_word,
  input  logic [31:0] back4_word,
  input  logic [7:0]  rcon,
  input  logic        first_word,
  output logic [31:0] new_word
);

  logic [31:0] rot_s;

  always_comb begin
    rot_s = {prev_word[23:0], prev_word[31:24]};
    if (first_word) begin
      new_word = back4_word ^ subword(rot_s) ^ {rcon, 24'h000000};
    end else begin
      new_word = back4_word ^ prev_word;
    end
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: one expanded word per cycle into an 11-slot store.
// Optional registered round-10 copy o_last_key when AES_KEYSCHED_LAST_KEY_EN is defined.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS_P = NUM_ROUNDS,
  parameter int RD_IDX_W     = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [0:127]        i_key,
  input  logic [RD_IDX_W-1:0] i_rd_round,
  output logic [0:127]        o_rd_key,
  output logic                o_busy,
  output logic                o_keys_valid,
  output logic                o_done
`ifdef AES_KEYSCHED_LAST_KEY_EN
  , output logic [0:127]      o_last_key
`endif
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   word_q, word_d;
  logic         keys_valid_q, keys_valid_d;
  logic         done_q, done_d;
  logic [0:127] key_store_q [0:NUM_RKEYS-1];
  logic [0:127] key_store_d [0:NUM_RKEYS-1];

  logic [3:0]   slot_s;
  logic [6:0]   cur_off_s;
  logic [6:0]   prev_off_s;
  logic [31:0]  prev_word_s;
  logic [31:0]  back4_word_s;
  logic [31:0]  step_word_s;
  logic [7:0]   rcon_s;

`ifdef AES_KEYSCHED_LAST_KEY_EN
  logic [0:127] last_key_q, last_key_d;
`endif

  // Operand fetch for the shared word step; word 0 of a round uses the last word of the previous slot.
  always_comb begin
    slot_s       = round_q + 4'd1;
    cur_off_s    = {word_q, 5'b00000};
    prev_off_s   = {word_q - 2'd1, 5'b00000};
    back4_word_s = key_store_q[round_q][cur_off_s +: 32];
    if (word_q == 2'd0) begin
      prev_word_s = key_store_q[round_q][96 +: 32];
    end else begin
      prev_word_s = key_store_q[slot_s][prev_off_s +: 32];
    end
    if (round_q < 4'(NUM_ROUNDS_P)) begin
      rcon_s = RCON[round_q];
    end else begin
      rcon_s = 8'h00;
    end
  end

  aes_key_word_step u_step (
    .prev_word  (prev_word_s),
    .back4_word (back4_word_s),
    .rcon       (rcon_s),
    .first_word (word_q == 2'd0),
    .new_word   (step_word_s)
  );

  // Next-state, counters and key-store update.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    word_d       = word_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    key_store_d  = key_store_q;
`ifdef AES_KEYSCHED_LAST_KEY_EN
    last_key_d   = last_key_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          key_store_d[0] = i_key;
          round_d        = 4'd0;
          word_d         = 2'd0;
          keys_valid_d   = 1'b0;
          state_d        = EXPAND;
        end else begin
          state_d = state_q;
        end
      end
      EXPAND: begin
        key_store_d[slot_s][cur_off_s +: 32] = step_word_s;
        if (word_q == 2'd3) begin
          word_d = 2'd0;
          if (round_q == 4'(NUM_ROUNDS_P - 1)) begin
            round_d      = 4'd0;
            state_d      = DONE;
            keys_valid_d = 1'b1;
            done_d       = 1'b1;
`ifdef AES_KEYSCHED_LAST_KEY_EN
            last_key_d   = {key_store_q[NUM_RKEYS-1][0:95], step_word_s};
`endif
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          word_d = word_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and key store; reset overrides everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      word_q       <= 2'd0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_RKEYS; i++) begin
        key_store_q[i] <= 128'h0;
      end
`ifdef AES_KEYSCHED_LAST_KEY_EN
      last_key_q   <= 128'h0;
`endif
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      word_q       <= word_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      key_store_q  <= key_store_d;
`ifdef AES_KEYSCHED_LAST_KEY_EN
      last_key_q   <= last_key_d;
`endif
    end
  end

  // Combinational round-key read; indices past round 10 read as zero.
  always_comb begin
    if (i_rd_round < RD_IDX_W'(NUM_RKEYS)) begin
      o_rd_key = key_store_q[i_rd_round];
    end else begin
      o_rd_key = 128'h0;
    end
  end

  assign o_busy       = (state_q == EXPAND);
  assign o_keys_valid = keys_valid_q;
  assign o_done       = done_q;
`ifdef AES_KEYSCHED_LAST_KEY_EN
  assign o_last_key   = last_key_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed self-checking bench for aes_key_schedule_ctrl using FIPS-197 key vectors.
// Also checks o_last_key when built with AES_KEYSCHED_LAST_KEY_EN.
module tb_aes_key_schedule_ctrl;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A_RX = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C_RX = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [0:127] i_key;
  logic [3:0]   i_rd_round;
  logic [0:127] o_rd_key;
  logic         o_busy;
  logic         o_keys_valid;
  logic         o_done;
`ifdef AES_KEYSCHED_LAST_KEY_EN
  logic [0:127] o_last_key;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  aes_key_schedule_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_key        (i_key),
    .i_rd_round   (i_rd_round),
    .o_rd_key     (o_rd_key),
    .o_busy       (o_busy),
    .o_keys_valid (o_keys_valid),
    .o_done       (o_done)
`ifdef AES_KEYSCHED_LAST_KEY_EN
    , .o_last_key (o_last_key)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int idx, input logic [127:0] exp);
    i_rd_round = 4'(idx);
    #1;
    check(tag, o_rd_key, exp);
  endtask

  // Counts negedges after the accept edge until o_done, bounded at 60.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!o_done && n < 60);
  endtask

  task automatic accept(input logic [127:0] key);
    i_key   = key;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
  endtask

  int n;
  int ndone;
  int done_at;

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_key      = 128'h0;
    i_rd_round = 4'd0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    check("rst_busy", o_busy, 128'h0);
    check("rst_valid", o_keys_valid, 128'h0);
    check("rst_done", o_done, 128'h0);
    read_check("rst_rd0", 0, 128'h0);

    // FIPS-197 A.1 expansion
    accept(KEY_A);
    check("a_busy", o_busy, 128'h1);
    check("a_valid_low", o_keys_valid, 128'h0);
    read_check("a_mid_rd11", 11, 128'h0);
    wait_done(n);
    check("a_latency", n, 128'd40);
    check("a_valid", o_keys_valid, 128'h1);
    check("a_busy_low", o_busy, 128'h0);
    read_check("a_rk0", 0, KEY_A);
    read_check("a_rk1", 1, KEY_A_R1);
    read_check("a_rk10", 10, KEY_A_RX);
    for (int i = 11; i < 16; i++) read_check("a_rd_oob", i, 128'h0);
`ifdef AES_KEYSCHED_LAST_KEY_EN
    check("a_last_key", o_last_key, KEY_A_RX);
`endif
    @(negedge i_clock);
    check("a_done_pulse", o_done, 128'h0);

    // i_start held high for 10 cycles after the accept
    i_key   = KEY_A;
    i_start = 1'b1;
    @(negedge i_clock);
    ndone   = 0;
    done_at = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge i_clock);
      if (c == 10) i_start = 1'b0;
      if (o_done) begin
        ndone++;
        done_at = c;
      end
    end
    check("hold_ndone", ndone, 128'd1);
    check("hold_done_at", done_at, 128'd40);
    read_check("hold_rk10", 10, KEY_A_RX);

    // Reset mid-expansion
    accept(KEY_C);
    repeat (19) @(negedge i_clock);
    check("mid_busy", o_busy, 128'h1);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    check("mrst_busy", o_busy, 128'h0);
    check("mrst_valid", o_keys_valid, 128'h0);
    for (int i = 0; i < 11; i++) read_check("mrst_rd", i, 128'h0);
`ifdef AES_KEYSCHED_LAST_KEY_EN
    check("mrst_last_key", o_last_key, 128'h0);
`endif
    accept(KEY_A);
    wait_done(n);
    check("post_rst_latency", n, 128'd40);
    read_check("post_rst_rk1", 1, KEY_A_R1);
    read_check("post_rst_rk10", 10, KEY_A_RX);

    // Restart from DONE with FIPS-197 C.1 key
    @(negedge i_clock);
    accept(KEY_C);
    check("c_valid_low", o_keys_valid, 128'h0);
    check("c_busy", o_busy, 128'h1);
    read_check("c_mid_rd15", 15, 128'h0);
`ifdef AES_KEYSCHED_LAST_KEY_EN
    check("c_last_key_held", o_last_key, KEY_A_RX);
`endif
    wait_done(n);
    check("c_latency", n, 128'd40);
    check("c_valid", o_keys_valid, 128'h1);
    read_check("c_rk0", 0, KEY_C);
    read_check("c_rk10", 10, KEY_C_RX);
`ifdef AES_KEYSCHED_LAST_KEY_EN
    check("c_last_key", o_last_key, KEY_C_RX);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
